// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the router ingress slice.
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DROP  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Destination field: low addr_w bits of the header word.
  function automatic int unsigned hdr_addr(input logic [31:0] word,
                                           input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return int'(word & mask);
  endfunction

  // Length field: header bits above the destination field.
  function automatic int unsigned hdr_len(input logic [31:0] word,
                                          input int unsigned addr_w,
                                          input int unsigned data_w);
    logic [31:0] mask;
    mask = (32'd1 << (data_w - addr_w)) - 32'd1;
    return int'((word >> addr_w) & mask);
  endfunction

endpackage

// File: rtl/router_src_ingress_if.sv
// Source-side and FIFO-side signals of the ingress stage.
interface router_src_ingress_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 3
);
  logic [DATA_W-1:0] data_in;
  logic              pkt_valid;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              error;

  // Environment side: drives packets and FIFO status.
  modport master (
    output data_in, pkt_valid, fifo_full,
    input  wr_en, wr_data, busy, error
  );

  // Ingress stage side.
  modport slave (
    input  data_in, pkt_valid, fifo_full,
    output wr_en, wr_data, busy, error
  );
endinterface

// File: rtl/router_skid2.sv
// Two-entry in-order buffer; entry 0 is always the head.
module router_skid2 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              head_valid,
  output logic [1:0]        level
);

  logic [DATA_W-1:0] ent0_q;
  logic [DATA_W-1:0] ent1_q;
  logic [1:0]        lvl_q;

  // Entry shift and occupancy update; caller never pushes into a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      lvl_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (lvl_q == 2'd0) ent0_q <= push_data;
          else               ent1_q <= push_data;
          lvl_q <= lvl_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          lvl_q  <= lvl_q - 2'd1;
        end
        2'b11: begin
          if (lvl_q == 2'd1) begin
            ent0_q <= push_data;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = ent0_q;
  assign head_valid = (lvl_q != 2'd0);
  assign level      = lvl_q;

endmodule

// File: rtl/router_src_ingress.sv
// Router ingress: header decode, parity/length check, steering into output FIFOs.
module router_src_ingress
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CH = 3
) (
  input  logic                 clock,
  input  logic                 resetn,
  router_src_ingress_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_CH);
  localparam int unsigned LEN_W  = DATA_W - ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] par_q;
  logic              mis_q;
  logic              busy_q;
  logic              error_q;

  logic [ADDR_W-1:0] hdr_addr_w;
  logic [LEN_W-1:0]  hdr_len_w;
  logic              hdr_ok;
  logic              accept;
  logic              push;
  logic              err_d;
  logic              pop;
  logic [NUM_CH-1:0] wr_en_c;
  logic [DATA_W-1:0] head;
  logic              head_valid;
  logic [1:0]        level;
  logic [1:0]        lvl_nxt;

  assign hdr_addr_w = ADDR_W'(hdr_addr(32'(bus.data_in), ADDR_W));
  assign hdr_len_w  = LEN_W'(hdr_len(32'(bus.data_in), ADDR_W, DATA_W));
  assign hdr_ok     = (32'(hdr_addr_w) < NUM_CH) && (hdr_len_w != '0);

  // Inside a packet every edge without busy consumes a word; in IDLE only a valid header.
  assign accept = ~busy_q & (((state_q == ST_IDLE) & bus.pkt_valid) |
                             (state_q == ST_LOAD) | (state_q == ST_DROP));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = hdr_ok ? ST_LOAD : ST_DROP;
      ST_LOAD,
      ST_DROP:  if (accept && !bus.pkt_valid) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state push decision and packet verdict on the parity word.
  always_comb begin
    push  = 1'b0;
    err_d = 1'b0;
    case (state_q)
      ST_IDLE: push = accept & hdr_ok;
      ST_LOAD: begin
        if (accept) begin
          if (bus.pkt_valid) begin
            push = (cnt_q < len_q);
          end else begin
            push  = 1'b1;
            err_d = (bus.data_in != par_q) | (cnt_q != len_q) | mis_q;
          end
        end
      end
      ST_DROP: err_d = accept & ~bus.pkt_valid;
      default: ;
    endcase
  end

  // Packet context: destination, length, running parity, payload count.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dest_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      par_q  <= '0;
      mis_q  <= 1'b0;
    end else if (state_q == ST_IDLE && accept && hdr_ok) begin
      dest_q <= hdr_addr_w;
      len_q  <= hdr_len_w;
      cnt_q  <= '0;
      par_q  <= bus.data_in;
      mis_q  <= 1'b0;
    end else if (state_q == ST_LOAD && accept && bus.pkt_valid) begin
      par_q <= par_q ^ bus.data_in;
      cnt_q <= cnt_q + LEN_W'(1);
      if (cnt_q >= len_q) mis_q <= 1'b1;
    end
  end

  router_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clk        (clock),
    .rst_n      (resetn),
    .push       (push),
    .push_data  (bus.data_in),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .level      (level)
  );

  // Write strobe to the selected channel only when it has room.
  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_wr
    assign wr_en_c[i] = head_valid & ~bus.fifo_full[i] & (dest_q == ADDR_W'(i));
  end

  assign pop     = |wr_en_c;
  assign lvl_nxt = level + {1'b0, push} - {1'b0, pop};

  // Backpressure and error pulse registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      busy_q  <= (lvl_nxt == 2'd2) | (state_d == ST_CHECK);
      error_q <= err_d;
    end
  end

  assign bus.wr_en   = wr_en_c;
  assign bus.wr_data = head;
  assign bus.busy    = busy_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_router_src_ingress.sv
// Directed bench for router_src_ingress with hand-computed expectations.
module tb_router_src_ingress;

  logic clock;
  logic resetn;
  int   vectors;
  int   miscompares;
  int   stalls;

  logic [2:0] log_en[$];
  logic [7:0] log_data[$];

  router_src_ingress_if #(.DATA_W(8), .NUM_CH(3)) bus_if ();

  router_src_ingress #(.DATA_W(8), .NUM_CH(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every FIFO write that happens on a rising edge.
  always @(posedge clock) begin
    if (resetn && bus_if.wr_en != 3'b000) begin
      log_en.push_back(bus_if.wr_en);
      log_data.push_back(bus_if.wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one word and hold it until an edge with busy low consumes it.
  task automatic send_word(input logic [7:0] d, input logic v);
    logic acc;
    acc = 1'b0;
    bus_if.data_in   = d;
    bus_if.pkt_valid = v;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (!bus_if.busy) acc = 1'b1;
      else              stalls++;
      tick();
    end
    check("word_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3, input int n,
                          input logic [7:0] par);
    logic [7:0] pl[4];
    pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3;
    send_word(hdr, 1'b1);
    for (int i = 0; i < n; i++) send_word(pl[i], 1'b1);
    send_word(par, 1'b0);
    bus_if.data_in = 8'h00;
  endtask

  // Compare the recorded writes against an expected channel and word list, then clear.
  task automatic check_log(input string tag, input logic [2:0] en, input logic [7:0] d0,
                           input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                           input logic [7:0] d4, input int n);
    logic [7:0] exp[5];
    exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3; exp[4] = d4;
    check({tag, "_count"}, 32'(log_en.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < log_en.size()) begin
        check({tag, "_en"}, 32'(log_en[i]), 32'(en));
        check({tag, "_data"}, 32'(log_data[i]), 32'(exp[i]));
      end
    end
    log_en.delete();
    log_data.delete();
  endtask

  task automatic after_parity(input string tag, input logic exp_err);
    check({tag, "_busy_check"}, 32'(bus_if.busy), 32'd1);
    check({tag, "_error"}, 32'(bus_if.error), 32'(exp_err));
    tick();
    check({tag, "_busy_idle"}, 32'(bus_if.busy), 32'd0);
    check({tag, "_error_clear"}, 32'(bus_if.error), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    stalls      = 0;
    resetn      = 1'b0;
    bus_if.data_in   = 8'h00;
    bus_if.pkt_valid = 1'b0;
    bus_if.fifo_full = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_error", 32'(bus_if.error), 32'd0);
    check("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("rst_wr_data", 32'(bus_if.wr_data), 32'd0);
    #2 resetn = 1'b1;
    tick();

    // Nominal packet to channel 1.
    stalls = 0;
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 3, 8'h0D);
    after_parity("nom", 1'b0);
    check_log("nom", 3'b010, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 5);
    check("nom_stalls", 32'(stalls), 32'd0);

    // Same packet with corrupted parity.
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 3, 8'h0C);
    after_parity("par", 1'b1);
    check_log("par", 3'b010, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C, 5);

    // Header to nonexistent channel 3 is dropped.
    stalls = 0;
    send_pkt(8'h0F, 8'h11, 8'h22, 8'h33, 8'h00, 3, 8'h0F);
    after_parity("drop", 1'b1);
    check_log("drop", 3'b000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    check("drop_stalls", 32'(stalls), 32'd0);

    // Backpressure: channel 1 full across header and first payload.
    bus_if.fifo_full = 3'b010;
    send_word(8'h0D, 1'b1);
    check("bp_wr_en_blocked", 32'(bus_if.wr_en), 32'd0);
    check("bp_busy_after_hdr", 32'(bus_if.busy), 32'd0);
    send_word(8'h11, 1'b1);
    check("bp_busy_rise", 32'(bus_if.busy), 32'd1);
    bus_if.data_in   = 8'h22;
    bus_if.pkt_valid = 1'b1;
    repeat (3) tick();
    check("bp_busy_hold", 32'(bus_if.busy), 32'd1);
    check("bp_no_writes", 32'(log_en.size()), 32'd0);
    bus_if.fifo_full = 3'b000;
    #1;
    check("bp_release_wr_en", 32'(bus_if.wr_en), 32'b010);
    check("bp_release_head", 32'(bus_if.wr_data), 32'h0D);
    tick();
    check("bp_busy_fall", 32'(bus_if.busy), 32'd0);
    send_word(8'h22, 1'b1);
    send_word(8'h33, 1'b1);
    send_word(8'h0D, 1'b0);
    bus_if.data_in = 8'h00;
    after_parity("bp", 1'b0);
    check_log("bp", 3'b010, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 5);

    // Four payloads against length 3: extra word discarded, parity 0x49 covers all.
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h44, 4, 8'h49);
    after_parity("len", 1'b1);
    check_log("len", 3'b010, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h49, 5);

    // Reset in the middle of a packet.
    send_word(8'h0D, 1'b1);
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b1);
    check("mid_wr_en_before", 32'(bus_if.wr_en), 32'b010);
    #1 resetn = 1'b0;
    bus_if.pkt_valid = 1'b0;
    bus_if.data_in   = 8'h00;
    #1;
    check("mid_rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("mid_rst_wr_data", 32'(bus_if.wr_data), 32'd0);
    check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
    check("mid_rst_error", 32'(bus_if.error), 32'd0);
    #1 resetn = 1'b1;
    tick();
    log_en.delete();
    log_data.delete();
    // Header 0x0A: addr 2, len 2; parity 0x0A^0x5A^0xA5 = 0xF5.
    send_pkt(8'h0A, 8'h5A, 8'hA5, 8'h00, 8'h00, 2, 8'hF5);
    after_parity("post", 1'b0);
    check_log("post", 3'b100, 8'h0A, 8'h5A, 8'hA5, 8'hF5, 8'h00, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
